// File: rtl/mem_pkg.sv
// Shared definitions for the data cache slice.
//   - load_type_e   : RISC-V load funct3 encodings understood by the cache
//   - cache_state_e : cache controller states
//   - default address split (offset / index / tag widths)
//   - store byte-enable and word-spill helpers
package mem_pkg;

  localparam int ADDR_BITS   = 32;
  localparam int IDX_BITS    = 6;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_BITS - IDX_BITS - OFFSET_BITS;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_type_e;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } cache_state_e;

  // Byte lanes written by a store, positioned at the byte offset.
  // Lanes shifted past byte 3 are dropped; those stores are spills.
  function automatic logic [3:0] store_byte_enable(input logic sw, input logic sh,
                                                   input logic sb, input logic [1:0] offset);
    logic [3:0] base;
    if (sw) begin
      base = 4'b1111;
    end else if (sh) begin
      base = 4'b0011;
    end else if (sb) begin
      base = 4'b0001;
    end else begin
      base = 4'b0000;
    end
    return base << offset;
  endfunction

  // True when a store crosses into the following word.
  function automatic logic store_spills(input logic sw, input logic sh, input logic [1:0] offset);
    return (sw && (offset != 2'd0)) || (sh && (offset == 2'd3));
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load extraction: selects the byte/half/word addressed by offset from a
// cached word and sign- or zero-extends it according to load_type.
//   word      in  WIDTH  aligned data word
//   offset    in  2      byte offset within the word
//   load_type in  3      RISC-V load funct3
//   rdata     out WIDTH  extended result (0 for undefined funct3)
module load_extend
  import mem_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] word,
  input  logic [1:0]       offset,
  input  logic [2:0]       load_type,
  output logic [WIDTH-1:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension.
  always_comb begin
    byte_s = word[{offset, 3'b000} +: 8];
    half_s = offset[1] ? word[31:16] : word[15:0];
    rdata  = {WIDTH{1'b0}};
    case (load_type_e'(load_type))
      LB:      rdata = {{(WIDTH-8){byte_s[7]}}, byte_s};
      LH:      rdata = {{(WIDTH-16){half_s[15]}}, half_s};
      LW:      rdata = word;
      LBU:     rdata = {{(WIDTH-8){1'b0}}, byte_s};
      LHU:     rdata = {{(WIDTH-16){1'b0}}, half_s};
      default: rdata = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// CPU memory stage and the data ram. One 32-bit word per line.
//   clk, rst              clock and synchronous active-high reset
//   addr, wdata           CPU byte address and right-aligned store data
//   load, load_type       load request and funct3
//   sw, sh, sb            store requests (at most one high)
//   rdata, stall          extended load result and pipeline freeze
//   mem_a, mem_wd         ram address and write data
//   mem_sw/mem_sh/mem_sb  ram store strobes
//   mem_rd                combinational word read data from ram
//   hit_count, miss_count saturating load hit/miss counters
module data_cache
  import mem_pkg::*;
#(
  parameter int ADDRESS_LENGTH = ADDR_BITS,
  parameter int INDEX_BITS     = IDX_BITS,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDRESS_LENGTH-1:0] addr,
  input  logic [ADDRESS_LENGTH-1:0] wdata,
  input  logic                      load,
  input  logic [2:0]                load_type,
  input  logic                      sw,
  input  logic                      sh,
  input  logic                      sb,
  output logic [ADDRESS_LENGTH-1:0] rdata,
  output logic                      stall,
  output logic [ADDRESS_LENGTH-1:0] mem_a,
  output logic [ADDRESS_LENGTH-1:0] mem_wd,
  output logic                      mem_sw,
  output logic                      mem_sh,
  output logic                      mem_sb,
  input  logic [ADDRESS_LENGTH-1:0] mem_rd,
  output logic [CNT_WIDTH-1:0]      hit_count,
  output logic [CNT_WIDTH-1:0]      miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAGW  = ADDRESS_LENGTH - INDEX_BITS - 2;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [INDEX_BITS-1:0] IDX_ONE = {{(INDEX_BITS-1){1'b0}}, 1'b1};

  logic [LINES-1:0]          valid_r;
  logic [TAGW-1:0]           tag_r  [LINES];
  logic [ADDRESS_LENGTH-1:0] data_r [LINES];

  cache_state_e state_r, state_next_s;
  logic [CNT_WIDTH-1:0] hit_count_r, miss_count_r;

  logic [1:0]                offset_s;
  logic [INDEX_BITS-1:0]     index_s, index_next_s;
  logic [TAGW-1:0]           tag_s;
  logic                      store_s, hit_s, spill_s;
  logic                      hit_inc_s, miss_inc_s;
  logic [ADDRESS_LENGTH-1:0] line_word_s, ext_s, shifted_s, merged_s;
  logic [3:0]                be_s;

  assign offset_s     = addr[1:0];
  assign index_s      = addr[INDEX_BITS+1:2];
  assign tag_s        = addr[ADDRESS_LENGTH-1:INDEX_BITS+2];
  assign index_next_s = index_s + IDX_ONE;   // wraps modulo line count
  assign store_s      = sw | sh | sb;
  assign line_word_s  = data_r[index_s];
  assign hit_s        = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign spill_s      = store_spills(sw, sh, offset_s);
  assign be_s         = store_byte_enable(sw, sh, sb, offset_s);
  assign shifted_s    = wdata << {offset_s, 3'b000};
  assign hit_count    = hit_count_r;
  assign miss_count   = miss_count_r;

  load_extend #(.WIDTH(ADDRESS_LENGTH)) u_load_extend (
    .word      (line_word_s),
    .offset    (offset_s),
    .load_type (load_type),
    .rdata     (ext_s)
  );

  // Store merge: replace only the byte lanes touched by the store.
  always_comb begin
    merged_s = line_word_s;
    for (int b = 0; b < 4; b++) begin
      if (be_s[b]) begin
        merged_s[8*b +: 8] = shifted_s[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = line_word_s[8*b +: 8];
      end
    end
  end

  // Next-state and ram/CPU outputs; a store wins over a simultaneous load.
  always_comb begin
    state_next_s = state_r;
    stall        = 1'b0;
    rdata        = {ADDRESS_LENGTH{1'b0}};
    mem_a        = addr;
    mem_wd       = {ADDRESS_LENGTH{1'b0}};
    mem_sw       = 1'b0;
    mem_sh       = 1'b0;
    mem_sb       = 1'b0;
    hit_inc_s    = 1'b0;
    miss_inc_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (store_s) begin
          mem_wd = wdata;
          mem_sw = sw;
          mem_sh = sh;
          mem_sb = sb;
        end else if (load) begin
          if (hit_s) begin
            rdata     = ext_s;
            hit_inc_s = 1'b1;
          end else begin
            stall        = 1'b1;
            miss_inc_s   = 1'b1;
            state_next_s = REFILL;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      REFILL: begin
        // CPU holds addr stable, so the line address is still on addr.
        stall        = 1'b1;
        mem_a        = {addr[ADDRESS_LENGTH-1:2], 2'b00};
        state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Controller state register; reset also aborts a refill in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Line array: refill, store-hit merge and spill invalidation.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (state_r == REFILL) begin
      valid_r[index_s] <= 1'b1;
      tag_r[index_s]   <= tag_s;
      data_r[index_s]  <= mem_rd;
    end else if (store_s && spill_s) begin
      valid_r[index_s]      <= 1'b0;
      valid_r[index_next_s] <= 1'b0;
    end else if (store_s && hit_s) begin
      data_r[index_s] <= merged_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_r  <= {CNT_WIDTH{1'b0}};
      miss_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (hit_inc_s && (hit_count_r != CNT_MAX)) begin
        hit_count_r <= hit_count_r + CNT_ONE;
      end
      if (miss_inc_s && (miss_count_r != CNT_MAX)) begin
        miss_count_r <= miss_count_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load, sw, sh, sb;
  logic [2:0]  load_type;
  logic [31:0] addr, wdata, mem_rd;
  logic [31:0] rdata, mem_a, mem_wd, hit_count, miss_count;
  logic        stall, mem_sw, mem_sh, mem_sb;
  // second instance with 3-bit counters to exercise saturation
  logic [31:0] s_rdata, s_mem_a, s_mem_wd;
  logic        s_stall, s_mem_sw, s_mem_sh, s_mem_sb;
  logic [2:0]  s_hit, s_miss;

  data_cache dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .load(load), .load_type(load_type),
    .sw(sw), .sh(sh), .sb(sb), .rdata(rdata), .stall(stall), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_sw(mem_sw), .mem_sh(mem_sh), .mem_sb(mem_sb), .mem_rd(mem_rd),
    .hit_count(hit_count), .miss_count(miss_count));

  data_cache #(.CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .load(load), .load_type(load_type),
    .sw(sw), .sh(sh), .sb(sb), .rdata(s_rdata), .stall(s_stall), .mem_a(s_mem_a), .mem_wd(s_mem_wd),
    .mem_sw(s_mem_sw), .mem_sh(s_mem_sh), .mem_sb(s_mem_sb), .mem_rd(mem_rd),
    .hit_count(s_hit), .miss_count(s_miss));

  // ---------------- reference model ----------------
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];
  bit          m_refill;
  longint      m_hits, m_misses;
  logic [31:0] ram [logic [29:0]];

  int checks = 0;
  int passed = 0;

  logic [31:0] l_rdata, l_mem_a;
  logic        l_stall, l_sw, l_sh, l_sb;
  logic        cur_stall;

  function automatic logic [31:0] ram_read(input logic [31:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (ram.exists(w)) return ram[w];
    return {w[15:0], ~w[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void ram_write_byte(input logic [31:0] a, input logic [7:0] d);
    logic [31:0] cur;
    cur = ram_read(a);
    cur[8*a[1:0] +: 8] = d;
    ram[a[31:2]] = cur;
  endfunction

  function automatic logic [31:0] model_extend(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] t);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * off[1])) & 32'h0000_FFFF;
    case (t)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b010:  return w;
      3'b100:  return b;
      3'b101:  return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] clip(input longint v, input longint maxv);
    return (v > maxv) ? maxv[31:0] : v[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic ld, input logic [2:0] lt, input logic [31:0] a,
                       input logic [31:0] wd, input logic s_w, input logic s_h, input logic s_b);
    rst = r; load = ld; load_type = lt; addr = a; wdata = wd; sw = s_w; sh = s_h; sb = s_b;
  endtask

  // One clock cycle: serve ram, compare outputs with the model, advance the model.
  task automatic step();
    logic [31:0] e_rdata, e_mem_a, e_mem_wd, refill_word, ram_a, ram_wd;
    logic        e_stall, e_sw, e_sh, e_sb, st, hit;
    logic [2:0]  rs;
    logic [5:0]  idx;
    int          n;
    #1;
    mem_rd = ram_read(mem_a);
    #1;
    idx = addr[7:2];
    st  = sw | sh | sb;
    hit = m_valid[idx] && (m_tag[idx] == addr[31:8]);
    e_rdata = 32'h0; e_mem_a = addr; e_mem_wd = 32'h0; e_stall = 1'b0;
    e_sw = 1'b0; e_sh = 1'b0; e_sb = 1'b0;
    if (m_refill) begin
      e_stall = 1'b1;
      e_mem_a = addr & 32'hFFFF_FFFC;
    end else if (st) begin
      e_mem_wd = wdata; e_sw = sw; e_sh = sh; e_sb = sb;
    end else if (load) begin
      if (hit) e_rdata = model_extend(m_data[idx], addr[1:0], load_type);
      else     e_stall = 1'b1;
    end
    chk("rdata", rdata, e_rdata);       chk("stall", {31'h0, stall}, {31'h0, e_stall});
    chk("mem_a", mem_a, e_mem_a);       chk("mem_wd", mem_wd, e_mem_wd);
    chk("mem_strobes", {29'h0, mem_sw, mem_sh, mem_sb}, {29'h0, e_sw, e_sh, e_sb});
    chk("hit_count", hit_count, clip(m_hits, 64'hFFFF_FFFF));
    chk("miss_count", miss_count, clip(m_misses, 64'hFFFF_FFFF));
    chk("sat_rdata", s_rdata, e_rdata); chk("sat_stall", {31'h0, s_stall}, {31'h0, e_stall});
    chk("sat_mem", s_mem_a ^ s_mem_wd ^ {29'h0, s_mem_sw, s_mem_sh, s_mem_sb},
        e_mem_a ^ e_mem_wd ^ {29'h0, e_sw, e_sh, e_sb});
    chk("sat_hit_count", {29'h0, s_hit}, clip(m_hits, 7));
    chk("sat_miss_count", {29'h0, s_miss}, clip(m_misses, 7));
    l_rdata = rdata; l_stall = stall; l_mem_a = mem_a; l_sw = mem_sw; l_sh = mem_sh; l_sb = mem_sb;
    cur_stall   = e_stall;
    refill_word = ram_read(e_mem_a);
    ram_a = mem_a; ram_wd = mem_wd; rs = {mem_sw, mem_sh, mem_sb};
    @(posedge clk);
    // ram side: apply whatever the cache put on its store port
    n = rs[2] ? 4 : rs[1] ? 2 : rs[0] ? 1 : 0;
    for (int k = 0; k < n; k++) ram_write_byte(ram_a + k, ram_wd[8*k +: 8]);
    // model side
    if (rst) begin
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
      m_refill = 1'b0; m_hits = 0; m_misses = 0;
    end else if (m_refill) begin
      m_valid[idx] = 1'b1; m_tag[idx] = addr[31:8]; m_data[idx] = refill_word;
      m_refill = 1'b0;
    end else if (st) begin
      if ((sw && addr[1:0] != 2'd0) || (sh && addr[1:0] == 2'd3)) begin
        m_valid[idx] = 1'b0;
        m_valid[idx + 6'd1] = 1'b0;
      end else if (hit) begin
        n = sw ? 4 : sh ? 2 : 1;
        for (int k = 0; k < n; k++) begin
          if (addr[1:0] + k < 4) m_data[idx][8*(addr[1:0]+k) +: 8] = wdata[8*k +: 8];
        end
      end
    end else if (load) begin
      if (hit) m_hits++;
      else begin
        m_misses++;
        m_refill = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Load that completes within a bounded number of cycles; returns the data.
  task automatic do_load(input logic [31:0] a, input logic [2:0] t, output logic [31:0] d);
    int cyc;
    drive(1'b0, 1'b1, t, a, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    step();
    while (l_stall && cyc < 4) begin
      step();
      cyc++;
    end
    if (cyc >= 4) chk("load_timeout", 32'h1, 32'h0);
    d = l_rdata;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  logic [31:0] d;
  logic [23:0] tags [3];
  int          r;
  logic [5:0]  ix;

  initial begin
    tags[0] = 24'h000100; tags[1] = 24'h000200; tags[2] = 24'h0ABCDE;
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_refill = 1'b0; m_hits = 0; m_misses = 0; mem_rd = 32'h0;
    ram[30'h0000_4000] = 32'hDEAD_BEEF;
    // bring both instances out of an unknown state before checking anything
    drive(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(negedge clk);
    do_reset();
    chk("reset_stall", {31'h0, l_stall}, 32'h0);
    chk("reset_hits", hit_count, 32'h0);

    // test 1: cold lw
    drive(1'b0, 1'b1, 3'b010, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t1_c0_stall", {31'h0, l_stall}, 32'h1);
    chk("t1_miss_count", miss_count, 32'h1);
    step();
    chk("t1_c1_mem_a", l_mem_a, 32'h0001_0000);
    chk("t1_c1_stall", {31'h0, l_stall}, 32'h1);
    step();
    chk("t1_c2_rdata", l_rdata, 32'hDEAD_BEEF);
    chk("t1_c2_stall", {31'h0, l_stall}, 32'h0);
    chk("t1_hit_count", hit_count, 32'h1);

    // test 2: extraction
    do_load(32'h0001_0003, 3'b000, d); chk("t2_lb", d, 32'hFFFF_FFDE);
    do_load(32'h0001_0003, 3'b100, d); chk("t2_lbu", d, 32'h0000_00DE);
    do_load(32'h0001_0002, 3'b001, d); chk("t2_lh", d, 32'hFFFF_DEAD);
    do_load(32'h0001_0000, 3'b101, d); chk("t2_lhu", d, 32'h0000_BEEF);

    // test 3: sb merge on a cached line
    drive(1'b0, 1'b0, 3'b010, 32'h0001_0001, 32'h0000_0012, 1'b0, 1'b0, 1'b1);
    step();
    chk("t3_mem_sb", {31'h0, l_sb}, 32'h1);
    chk("t3_mem_a", l_mem_a, 32'h0001_0001);
    drive(1'b0, 1'b1, 3'b010, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_lw_stall", {31'h0, l_stall}, 32'h0);
    chk("t3_lw", l_rdata, 32'hDEAD_12EF);

    // test 4: store miss is write-through only
    drive(1'b0, 1'b0, 3'b010, 32'h0002_0000, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0);
    step();
    chk("t4_stall", {31'h0, l_stall}, 32'h0);
    chk("t4_mem_sw", {31'h0, l_sw}, 32'h1);
    chk("t4_hits", hit_count, 32'd6);
    chk("t4_misses", miss_count, 32'd1);
    do_load(32'h0002_0000, 3'b010, d);
    chk("t4_lw", d, 32'hCAFE_F00D);
    chk("t4_misses_after", miss_count, 32'd2);

    // test 5: aliasing
    do_reset();
    do_load(32'h0001_0000, 3'b010, d);
    do_load(32'h0001_0100, 3'b010, d);
    do_load(32'h0001_0000, 3'b010, d);
    chk("t5_misses", miss_count, 32'd3);

    // test 6a: reset during refill aborts the fill
    drive(1'b0, 1'b1, 3'b010, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b1, 1'b1, 3'b010, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 1'b1, 3'b010, 32'h0003_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6_after_reset_miss", {31'h0, l_stall}, 32'h1);
    step(); step();

    // test 6b: misaligned sh invalidates index and index+1
    do_load(32'h0001_0000, 3'b010, d);
    do_load(32'h0001_0004, 3'b010, d);
    drive(1'b0, 1'b0, 3'b010, 32'h0001_0003, 32'h0000_BBAA, 1'b0, 1'b1, 1'b0);
    step();
    chk("t6_sh_strobe", {31'h0, l_sh}, 32'h1);
    drive(1'b0, 1'b1, 3'b010, 32'h0001_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6_idx_invalid", {31'h0, l_stall}, 32'h1);
    step(); step();
    drive(1'b0, 1'b1, 3'b010, 32'h0001_0004, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t6_idx1_invalid", {31'h0, l_stall}, 32'h1);
    step(); step();

    // test 6c: counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 9; i++) do_load(32'h0001_0004, 3'b010, d);
    chk("t6_sat_hold", {29'h0, s_hit}, 32'd7);
    chk("t6_wide_hits", hit_count, 32'd9);

    // randomized traffic
    cur_stall = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      if (m_refill || cur_stall) begin
        rst = ($urandom_range(0, 29) == 0);
      end else begin
        r  = $urandom_range(0, 9);
        ix = 6'($urandom_range(0, 7));
        if (ix == 6'd6) ix = 6'd62;
        if (ix == 6'd7) ix = 6'd63;
        addr      = {tags[$urandom_range(0, 2)], ix, 2'($urandom_range(0, 3))};
        wdata     = $urandom;
        load_type = 3'($urandom_range(0, 7));
        load      = (r <= 5) || (r == 8);
        sw = 1'b0; sh = 1'b0; sb = 1'b0;
        if (r == 6 || r == 7 || r == 8) begin
          case ($urandom_range(0, 2))
            0:       sw = 1'b1;
            1:       sh = 1'b1;
            default: sb = 1'b1;
          endcase
        end
        rst = ($urandom_range(0, 299) == 0);
      end
      step();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
